tmr_fault_monitor: RTL and testbench

- Sits directly downstream of the triplicated counter and its majority voter.
- Watches the three replica values against the voted value, one sample per enabled clock.
- Keeps per-replica statistics and classifies each replica as healthy, transiently faulty or permanently faulty.
- Logs fault-onset events into a small FIFO drained over a valid/ready handshake by a status/debug reader.

---
 rtl/tmr_fault_monitor.sv | 176 +++++++++++++++++
 tb/tb_tmr_fault_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor: compares three replica values against the voted value,
// tracks per-replica health (OK / TRANSIENT / PERMANENT), counts fault onsets
// and logs onset events into a small valid/ready FIFO.
module tmr_fault_monitor #(
   parameter int width   = 64,
   parameter int cnt_w   = 8,
   parameter int persist = 4,
   parameter int depth   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic             clr_stats,
   input  logic [width-1:0] q_1,
   input  logic [width-1:0] q_2,
   input  logic [width-1:0] q_3,
   input  logic [width-1:0] voted_q,
   output logic [cnt_w-1:0] fault_cnt_1,
   output logic [cnt_w-1:0] fault_cnt_2,
   output logic [cnt_w-1:0] fault_cnt_3,
   output logic [2:0]       perm_fault,
   output logic             no_majority,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [1:0]       evt_code,
   output logic [width-1:0] evt_value,
   output logic             evt_overflow
);

   typedef enum logic [1:0] {OK, TRANSIENT, PERMANENT} state_t;

   localparam int         aw        = $clog2(depth);
   localparam logic [7:0] persist_c = 8'(persist);
   localparam logic [aw:0] depth_c  = (aw+1)'(depth);

   state_t           state [3];
   logic [7:0]       run   [3];
   logic [cnt_w-1:0] cnt   [3];

   logic [2:0] mismatch;
   logic [2:0] onset;
   logic       all_differ;

   logic [1:0]       code_mem  [depth];
   logic [width-1:0] value_mem [depth];
   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [aw:0]      count;

   logic       push;
   logic       pop;
   logic       full;
   logic       do_push;
   logic [1:0] push_code;

   assign mismatch   = {q_3 != voted_q, q_2 != voted_q, q_1 != voted_q};
   assign all_differ = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);

   // An onset is a sampled mismatch on a replica currently considered healthy
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         onset[i] = sample_en && (state[i] == OK) && mismatch[i];
      end
   end

   // Event code: replica index for a single onset, 00 when several coincide
   always_comb begin
      push_code = 2'b00;
      case (onset)
         3'b001:  push_code = 2'b01;
         3'b010:  push_code = 2'b10;
         3'b100:  push_code = 2'b11;
         default: push_code = 2'b00;
      endcase
   end

   assign push      = |onset;
   assign evt_valid = (count != '0);
   assign pop       = evt_valid && evt_ready;
   assign full      = (count == depth_c);
   assign do_push   = push && (!full || pop);

   // Per-replica health FSM, onset counters, permanent flags and no-majority flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            state[i] <= OK;
            run[i]   <= '0;
            cnt[i]   <= '0;
         end
         perm_fault  <= '0;
         no_majority <= 1'b0;
      end else if (clr_stats) begin
         for (int i = 0; i < 3; i++) begin
            state[i] <= OK;
            run[i]   <= '0;
            cnt[i]   <= '0;
         end
         perm_fault  <= '0;
         no_majority <= 1'b0;
      end else if (sample_en) begin
         if (all_differ) begin
            no_majority <= 1'b1;
         end
         for (int i = 0; i < 3; i++) begin
            case (state[i])
               OK: begin
                  if (mismatch[i]) begin
                     state[i] <= TRANSIENT;
                     run[i]   <= 8'd1;
                     if (cnt[i] != '1) begin
                        cnt[i] <= cnt[i] + 1'b1;
                     end
                  end
               end
               TRANSIENT: begin
                  if (!mismatch[i]) begin
                     state[i] <= OK;
                     run[i]   <= '0;
                  end else begin
                     run[i] <= run[i] + 8'd1;
                     if (run[i] + 8'd1 == persist_c) begin
                        state[i]      <= PERMANENT;
                        perm_fault[i] <= 1'b1;
                     end
                  end
               end
               default: begin
                  state[i] <= state[i];
               end
            endcase
         end
      end
   end

   // Event FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         evt_overflow <= 1'b0;
      end else if (clr_stats) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         evt_overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{aw{1'b0}}, do_push} - {{aw{1'b0}}, pop};
         if (push && full && !pop) begin
            evt_overflow <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because occupancy gates visibility
   always_ff @(posedge clk) begin
      if (rst && !clr_stats && do_push) begin
         code_mem[wr_ptr]  <= push_code;
         value_mem[wr_ptr] <= voted_q;
      end
   end

   assign evt_code    = evt_valid ? code_mem[rd_ptr]  : 2'b00;
   assign evt_value   = evt_valid ? value_mem[rd_ptr] : '0;
   assign fault_cnt_1 = cnt[0];
   assign fault_cnt_2 = cnt[1];
   assign fault_cnt_3 = cnt[2];

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: a table of directed vectors with
// hand-computed expected outputs, plus hand-written saturation and reset sequences.
module tb_tmr_fault_monitor;

   typedef struct packed {
      logic [7:0]  c1;
      logic [7:0]  c2;
      logic [7:0]  c3;
      logic [2:0]  perm;
      logic        nm;
      logic        vld;
      logic [1:0]  code;
      logic [63:0] val;
      logic        ovf;
   } out_t;

   typedef struct {
      string       name;
      logic        se;
      logic        clr;
      logic        rdy;
      logic [63:0] q1;
      logic [63:0] q2;
      logic [63:0] q3;
      logic [63:0] v;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_en;
   logic        clr_stats;
   logic [63:0] q_1, q_2, q_3, voted_q;
   logic [7:0]  fault_cnt_1, fault_cnt_2, fault_cnt_3;
   logic [2:0]  perm_fault;
   logic        no_majority;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_code;
   logic [63:0] evt_value;
   logic        evt_overflow;

   int checks = 0;
   int passed = 0;
   vec_t vecs[$];

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   tmr_fault_monitor #(.width(64), .cnt_w(8), .persist(4), .depth(4)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .clr_stats(clr_stats),
      .q_1(q_1), .q_2(q_2), .q_3(q_3), .voted_q(voted_q),
      .fault_cnt_1(fault_cnt_1), .fault_cnt_2(fault_cnt_2), .fault_cnt_3(fault_cnt_3),
      .perm_fault(perm_fault), .no_majority(no_majority),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_value(evt_value), .evt_overflow(evt_overflow)
   );

   function automatic out_t mkExp(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                                  input logic [2:0] perm, input logic nm, input logic vld,
                                  input logic [1:0] code, input logic [63:0] val, input logic ovf);
      out_t e;
      e.c1 = c1; e.c2 = c2; e.c3 = c3; e.perm = perm; e.nm = nm;
      e.vld = vld; e.code = code; e.val = val; e.ovf = ovf;
      return e;
   endfunction

   task automatic add(input string name, input logic se, input logic clr, input logic rdy,
                      input logic [63:0] q1, input logic [63:0] q2, input logic [63:0] q3,
                      input logic [63:0] v, input out_t e);
      vec_t x;
      x.name = name; x.se = se; x.clr = clr; x.rdy = rdy;
      x.q1 = q1; x.q2 = q2; x.q3 = q3; x.v = v; x.exp = e;
      vecs.push_back(x);
   endtask

   task automatic drive(input logic se, input logic clr, input logic rdy,
                        input logic [63:0] q1, input logic [63:0] q2, input logic [63:0] q3,
                        input logic [63:0] v);
      sample_en = se; clr_stats = clr; evt_ready = rdy;
      q_1 = q1; q_2 = q2; q_3 = q3; voted_q = v;
   endtask

   // Drive one vector, let one clock edge happen, then settle before sampling
   task automatic applyStimulus(input vec_t x);
      drive(x.se, x.clr, x.rdy, x.q1, x.q2, x.q3, x.v);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input out_t e);
      out_t a;
      a = mkExp(fault_cnt_1, fault_cnt_2, fault_cnt_3, perm_fault, no_majority,
                evt_valid, evt_code, evt_value, evt_overflow);
      checks++;
      if (a !== e) begin
         $display("[TB] FAIL %s: got cnt=%0d/%0d/%0d perm=%b nm=%b vld=%b code=%b val=%0d ovf=%b, expected cnt=%0d/%0d/%0d perm=%b nm=%b vld=%b code=%b val=%0d ovf=%b",
                  name, a.c1, a.c2, a.c3, a.perm, a.nm, a.vld, a.code, a.val, a.ovf,
                  e.c1, e.c2, e.c3, e.perm, e.nm, e.vld, e.code, e.val, e.ovf);
      end else begin
         passed++;
      end
   endtask

   task automatic checkCount(input string name, input logic [7:0] e);
      checks++;
      if (fault_cnt_1 !== e) begin
         $display("[TB] FAIL %s: fault_cnt_1 got %0d, expected %0d", name, fault_cnt_1, e);
      end else begin
         passed++;
      end
   endtask

   // Test sequence: reset check, table-driven vectors, then saturation and mid-run reset
   initial begin
      out_t zero;
      zero = mkExp(0, 0, 0, 3'b000, 0, 0, 2'b00, 64'd0, 0);

      rst = 1'b0;
      drive(0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", zero);
      rst = 1'b1;

      // Healthy samples
      for (int i = 0; i < 10; i++) add("idle", 1, 0, 1, 5, 5, 5, 5, zero);
      // Single transient on replica 2
      add("r2_onset",        1, 0, 1, 5, 7, 5, 5, mkExp(0, 1, 0, 3'b000, 0, 1, 2'b10, 5, 0));
      add("r2_recover_hold", 1, 0, 0, 5, 5, 5, 5, mkExp(0, 1, 0, 3'b000, 0, 1, 2'b10, 5, 0));
      add("r2_pop",          0, 0, 1, 5, 5, 5, 5, mkExp(0, 1, 0, 3'b000, 0, 0, 2'b00, 0, 0));
      // Replica 3 stuck: becomes permanent on the 4th mismatching sample
      add("r3_mis1",         1, 0, 1, 5, 5, 9, 5, mkExp(0, 1, 1, 3'b000, 0, 1, 2'b11, 5, 0));
      add("r3_mis2",         1, 0, 1, 5, 5, 9, 5, mkExp(0, 1, 1, 3'b000, 0, 0, 2'b00, 0, 0));
      add("r3_mis3",         1, 0, 1, 5, 5, 9, 5, mkExp(0, 1, 1, 3'b000, 0, 0, 2'b00, 0, 0));
      add("r3_perm",         1, 0, 1, 5, 5, 9, 5, mkExp(0, 1, 1, 3'b100, 0, 0, 2'b00, 0, 0));
      add("r3_mis5_no_evt",  1, 0, 1, 5, 5, 9, 5, mkExp(0, 1, 1, 3'b100, 0, 0, 2'b00, 0, 0));
      add("clr1",            1, 1, 1, 5, 5, 9, 5, zero);
      add("r3_after_clr",    1, 0, 0, 5, 5, 9, 5, mkExp(0, 0, 1, 3'b000, 0, 1, 2'b11, 5, 0));
      add("clr2",            1, 1, 1, 5, 5, 5, 5, zero);
      // FIFO fill with consumer stalled, then overflow, then push+pop while full
      add("d1",   1, 0, 0,  0, 10, 10, 10, mkExp(1, 0, 0, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d1m",  1, 0, 0, 10, 10, 10, 10, mkExp(1, 0, 0, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d2",   1, 0, 0, 11,  0, 11, 11, mkExp(1, 1, 0, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d2m",  1, 0, 0, 11, 11, 11, 11, mkExp(1, 1, 0, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d3",   1, 0, 0, 12, 12,  0, 12, mkExp(1, 1, 1, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d3m",  1, 0, 0, 12, 12, 12, 12, mkExp(1, 1, 1, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d4",   1, 0, 0,  0, 13, 13, 13, mkExp(2, 1, 1, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d4m",  1, 0, 0, 13, 13, 13, 13, mkExp(2, 1, 1, 3'b000, 0, 1, 2'b01, 10, 0));
      add("d5_drop",   1, 0, 0, 14,  0, 14, 14, mkExp(2, 2, 1, 3'b000, 0, 1, 2'b01, 10, 1));
      add("d6_pushpop",1, 0, 1, 15, 15,  0, 15, mkExp(2, 2, 2, 3'b000, 0, 1, 2'b10, 11, 1));
      add("drain1", 0, 0, 1, 15, 15, 15, 15, mkExp(2, 2, 2, 3'b000, 0, 1, 2'b11, 12, 1));
      add("drain2", 0, 0, 1, 15, 15, 15, 15, mkExp(2, 2, 2, 3'b000, 0, 1, 2'b01, 13, 1));
      add("drain3", 0, 0, 1, 15, 15, 15, 15, mkExp(2, 2, 2, 3'b000, 0, 1, 2'b11, 15, 1));
      add("drain4", 0, 0, 1, 15, 15, 15, 15, mkExp(2, 2, 2, 3'b000, 0, 0, 2'b00, 0, 1));
      add("clr3",   0, 1, 1, 15, 15, 15, 15, zero);
      // All three replicas differ: no majority, one combined event
      add("nomaj",     1, 0, 0, 1, 2, 4, 7, mkExp(1, 1, 1, 3'b000, 1, 1, 2'b00, 7, 0));
      add("nomaj_pop", 0, 0, 1, 1, 2, 4, 7, mkExp(1, 1, 1, 3'b000, 1, 0, 2'b00, 0, 0));
      add("clr4",      0, 1, 1, 7, 7, 7, 7, zero);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, vecs[i].exp);
      end

      // Saturation of the replica 1 onset counter
      for (int k = 0; k < 255; k++) begin
         drive(1, 0, 1, 64'd1, 64'd0, 64'd0, 64'd0);
         @(posedge clk); #1;
         drive(1, 0, 1, 64'd0, 64'd0, 64'd0, 64'd0);
         @(posedge clk); #1;
      end
      checkCount("cnt1_at_255", 8'd255);
      drive(1, 0, 1, 64'd1, 64'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
      checkCount("cnt1_saturated", 8'd255);

      // Asynchronous reset in the middle of an onset burst
      drive(1, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
      drive(1, 0, 0, 64'd1, 64'd2, 64'd3, 64'd0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_reset_immediate", zero);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(0, 0, 1, 64'd0, 64'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
      checkOutput("after_reset_release", zero);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
